// File: rtl/uart_tx_fifo_if.sv
// Byte-push / drain-control bundle between the CPU subsystem and the UART TX path.
// The subsystem side is the master; the UART block is the slave.
interface uart_tx_fifo_if #(
    parameter int NB_UART_DATA    = 8,
    parameter int FIFO_ADDR_WIDTH = 4
);
    logic                       i_wr;
    logic [NB_UART_DATA-1:0]    i_wdata;
    logic                       i_tx_start;
    logic                       o_tx;
    logic                       o_tx_done;
    logic                       o_busy;
    logic                       o_full;
    logic                       o_empty;
    logic [FIFO_ADDR_WIDTH:0]   o_count;
    logic                       o_overflow;

    modport master (
        output i_wr, i_wdata, i_tx_start,
        input  o_tx, o_tx_done, o_busy, o_full, o_empty, o_count, o_overflow
    );

    modport slave (
        input  i_wr, i_wdata, i_tx_start,
        output o_tx, o_tx_done, o_busy, o_full, o_empty, o_count, o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Bytes are queued with i_wr; a single i_tx_start pulse drains the whole FIFO
// as back-to-back 8N1 frames, LSB first, at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
    parameter int NB_UART_DATA    = 8,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int CLKS_PER_BIT    = 868
) (
    input  logic            clk,
    input  logic            i_rst,
    uart_tx_fifo_if.slave   bus
);
    localparam int DEPTH  = 2 ** FIFO_ADDR_WIDTH;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (NB_UART_DATA > 1) ? $clog2(NB_UART_DATA) : 1;
    localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_UART_DATA - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [NB_UART_DATA-1:0]    mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       overflow;

    // Serialiser state
    state_t                     state;
    logic [BAUD_W-1:0]          baud;
    logic [BIT_W-1:0]           bit_cnt;
    logic [NB_UART_DATA-1:0]    shift;
    logic [NB_UART_DATA-1:0]    shift_nxt;
    logic                       baud_done;
    logic                       drain;
    logic                       tx;
    logic                       tx_done;

    // Flags come from the registered count, so they reflect pre-edge state.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push      = bus.i_wr && !full;
    assign baud_done = (baud == BAUD_LAST);
    assign shift_nxt = shift >> 1;

    // A pop happens only when the FSM loads a new frame: leaving IDLE, or
    // chaining straight from a stop bit into the next start bit.
    assign pop = !empty &&
                 (((state == IDLE) && (drain || bus.i_tx_start)) ||
                  ((state == STOP) && baud_done && drain));

    // FIFO storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: any push attempted while full is dropped and flagged.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (bus.i_wr && full) begin
            overflow <= 1'b1;
        end
    end

    // Drain flag: armed by a start pulse on a non-empty FIFO, dropped when the
    // last frame's stop bit ends with nothing left to send.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            drain <= 1'b0;
        end else if ((state == STOP) && baud_done && !pop) begin
            drain <= 1'b0;
        end else if (bus.i_tx_start && !empty) begin
            drain <= 1'b1;
        end
    end

    // Frame serialiser: start bit, NB_UART_DATA data bits LSB first, stop bit.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state <= START;
                        shift <= mem[rd_ptr];
                        baud  <= '0;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift_nxt;
                            tx      <= shift_nxt[0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        tx_done <= 1'b1;
                        baud    <= '0;
                        if (pop) begin
                            state <= START;
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_tx       = tx;
    assign bus.o_tx_done  = tx_done;
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit.
module tb_uart_tx_fifo;
    localparam int NB    = 8;
    localparam int AW    = 4;
    localparam int CPB   = 4;
    localparam int FRAME = (NB + 2) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_tx_fifo_if #(.NB_UART_DATA(NB), .FIFO_ADDR_WIDTH(AW)) bus ();

    uart_tx_fifo #(
        .NB_UART_DATA(NB),
        .FIFO_ADDR_WIDTH(AW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .i_rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.i_wr    = 1'b1;
        bus.i_wdata = d;
        tick();
        bus.i_wr    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_tx_start = 1'b1;
        tick();
        bus.i_tx_start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Samples one frame starting at its first low cycle. bits[k] is the line
    // level at the start of bit period k; stable drops if the line moves
    // inside a bit period; early flags tx_done inside the frame; done_end is
    // tx_done in the cycle right after the frame.
    task automatic capture_frame(input int push_at, input logic [7:0] push_data,
                                 output logic [9:0] bits, output logic stable,
                                 output logic early, output logic done_end);
        bits   = '0;
        stable = 1'b1;
        early  = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i % CPB == 0) bits[i / CPB] = bus.o_tx;
            else if (bus.o_tx !== bits[i / CPB]) stable = 1'b0;
            if (i > 0 && bus.o_tx_done !== 1'b0) early = 1'b1;
            if (i == push_at) begin
                bus.i_wr    = 1'b1;
                bus.i_wdata = push_data;
            end
            tick();
            bus.i_wr = 1'b0;
        end
        done_end = bus.o_tx_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.o_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.o_tx); end
        total++; if (bus.o_tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.o_tx_done); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        total++; if (bus.o_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.o_full); end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.o_empty); end
        total++; if (bus.o_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.o_count); end
        total++; if (bus.o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.o_overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [9:0] bits;
        logic st, ed, de;
        push_byte(8'hA5);
        pulse_start();
        capture_frame(-1, 8'h00, bits, st, ed, de);
        // line sequence 0,1,0,1,0,0,1,0,1,1 with bit 0 first
        total++; if (bits !== 10'b1101001010) begin bad++; $display("FAIL a5_bits: got %b want 1101001010", bits); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL a5_stable: got %b want 1", st); end
        total++; if (ed !== 1'b0) begin bad++; $display("FAIL a5_early_done: got %b want 0", ed); end
        total++; if (de !== 1'b1) begin bad++; $display("FAIL a5_done_at_40: got %b want 1", de); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL a5_busy_after: got %b want 0", bus.o_busy); end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL a5_empty_after: got %b want 1", bus.o_empty); end
        tick();
        total++; if (bus.o_tx_done !== 1'b0) begin bad++; $display("FAIL a5_done_width: got %b want 0", bus.o_tx_done); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        logic [9:0] exp_frames [3];
        logic st, ed, de;
        exp_frames[0] = 10'b1000000010;
        exp_frames[1] = 10'b1000000100;
        exp_frames[2] = 10'b1000000110;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            capture_frame(-1, 8'h00, bits, st, ed, de);
            total++; if (bits !== exp_frames[k]) begin bad++; $display("FAIL b2b_bits[%0d]: got %b want %b", k, bits, exp_frames[k]); end
            total++; if ((st & ~ed & de) !== 1'b1) begin bad++; $display("FAIL b2b_timing[%0d]: stable=%b early=%b done=%b want 1,0,1", k, st, ed, de); end
        end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_after: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_overflow();
        logic [9:0] bits;
        logic st, ed, de;
        int bad_frames;
        for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
        total++; if (bus.o_full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", bus.o_full); end
        total++; if (bus.o_count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", bus.o_count); end
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.o_overflow); end
        pulse_start();
        bad_frames = 0;
        for (int k = 0; k < 16; k++) begin
            capture_frame(-1, 8'h00, bits, st, ed, de);
            if (bits !== {1'b1, 8'h10 + 8'(k), 1'b0} || st !== 1'b1 || de !== 1'b1) begin
                bad_frames++;
                $display("FAIL ovf_frame[%0d]: got %b want %b", k, bits, {1'b1, 8'h10 + 8'(k), 1'b0});
            end
        end
        total++; if (bad_frames != 0) begin bad++; $display("FAIL ovf_drain: got %0d bad frames want 0", bad_frames); end
        total++; if ((bus.o_busy | ~bus.o_empty) !== 1'b0) begin bad++; $display("FAIL ovf_idle_after: busy=%b empty=%b want 0,1", bus.o_busy, bus.o_empty); end
    endtask

    task automatic test_empty_start_and_late_push();
        logic [9:0] bits;
        logic st, ed, de;
        logic saw_activity;
        pulse_start();
        saw_activity = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1 || bus.o_tx_done !== 1'b0) saw_activity = 1'b1;
            tick();
        end
        total++; if (saw_activity !== 1'b0) begin bad++; $display("FAIL empty_start: got activity=%b want 0", saw_activity); end
        push_byte(8'h3C);
        pulse_start();
        capture_frame(10, 8'hC3, bits, st, ed, de);
        total++; if (bits !== 10'b1001111000) begin bad++; $display("FAIL late_first: got %b want 1001111000", bits); end
        total++; if (de !== 1'b1) begin bad++; $display("FAIL late_first_done: got %b want 1", de); end
        capture_frame(-1, 8'h00, bits, st, ed, de);
        total++; if (bits !== 10'b1110000110) begin bad++; $display("FAIL late_second: got %b want 1110000110", bits); end
        total++; if ((st & ~ed & de) !== 1'b1) begin bad++; $display("FAIL late_second_timing: stable=%b early=%b done=%b want 1,0,1", st, ed, de); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL late_busy_after: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        logic st, ed, de;
        logic saw_activity;
        push_byte(8'hA5);
        push_byte(8'h55);
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        total++; if (bus.o_tx !== 1'b0) begin bad++; $display("FAIL rstmid_pre_tx: got %b want 0", bus.o_tx); end
        rst = 1'b1;
        #1;
        total++; if (bus.o_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", bus.o_tx); end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b want 1", bus.o_empty); end
        total++; if (bus.o_overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", bus.o_overflow); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.o_busy); end
        tick();
        rst = 1'b0;
        saw_activity = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.o_tx_done !== 1'b0 || bus.o_tx !== 1'b1) saw_activity = 1'b1;
            tick();
        end
        total++; if (saw_activity !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: got activity=%b want 0", saw_activity); end
        push_byte(8'h5A);
        pulse_start();
        capture_frame(-1, 8'h00, bits, st, ed, de);
        total++; if (bits !== 10'b1010110100) begin bad++; $display("FAIL rstmid_fresh: got %b want 1010110100", bits); end
        total++; if ((st & ~ed & de) !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_timing: stable=%b early=%b done=%b want 1,0,1", st, ed, de); end
    endtask

    task automatic test_full_pop_push();
        logic [9:0] bits;
        logic st, ed, de;
        pulse_reset();
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        total++; if (bus.o_count !== 5'd16) begin bad++; $display("FAIL fpp_fill: got %0d want 16", bus.o_count); end
        bus.i_tx_start = 1'b1;
        bus.i_wr       = 1'b1;
        bus.i_wdata    = 8'hEE;
        tick();
        bus.i_tx_start = 1'b0;
        bus.i_wr       = 1'b0;
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL fpp_ovf: got %b want 1", bus.o_overflow); end
        total++; if (bus.o_count !== 5'd15) begin bad++; $display("FAIL fpp_count: got %0d want 15", bus.o_count); end
        total++; if (bus.o_full !== 1'b0) begin bad++; $display("FAIL fpp_full: got %b want 0", bus.o_full); end
        capture_frame(-1, 8'h00, bits, st, ed, de);
        total++; if (bits !== 10'b1001000000) begin bad++; $display("FAIL fpp_head: got %b want 1001000000", bits); end
        pulse_reset();
    endtask

    initial begin
        bus.i_wr       = 1'b0;
        bus.i_wdata    = '0;
        bus.i_tx_start = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_empty_start_and_late_push();
        test_reset_mid_frame();
        test_full_pop_push();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
